// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I hazard controller: opcode constants,
// controller state encoding and the shadow-pipeline slot record.
package rv32i_pkg;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } slot_t;

  // True when an in-flight slot will write the given source register.
  function automatic logic slot_hit(input slot_t s, input logic [4:0] r);
    return s.valid && (s.rd == r);
  endfunction

endpackage

// File: rtl/rv32i_iw_decode.sv
// Register-usage decode of an RV32I instruction word: which sources are
// read and whether a (nonzero) destination is written.
module rv32i_iw_decode
  import rv32i_pkg::*;
(
  input  logic [31:0] id_iw,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        rs1_used,
  output logic        rs2_used,
  output logic        wr_en,
  output logic [4:0]  rd
);

  logic [6:0] opcode;
  logic       writes_rd;
  // funct fields do not affect register usage.
  logic       unused_funct;

  assign opcode       = id_iw[6:0];
  assign rd           = id_iw[11:7];
  assign rs1          = id_iw[19:15];
  assign rs2          = id_iw[24:20];
  assign unused_funct = ^{id_iw[31:25], id_iw[14:12]};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    writes_rd = 1'b0;
    unique case (opcode)
      OP_REG:    begin rs1_used = 1'b1; rs2_used = 1'b1; writes_rd = 1'b1; end
      OP_IMM:    begin rs1_used = 1'b1; writes_rd = 1'b1; end
      OP_LOAD:   begin rs1_used = 1'b1; writes_rd = 1'b1; end
      OP_STORE:  begin rs1_used = 1'b1; rs2_used = 1'b1; end
      OP_BRANCH: begin rs1_used = 1'b1; rs2_used = 1'b1; end
      OP_JALR:   begin rs1_used = 1'b1; writes_rd = 1'b1; end
      OP_JAL:    writes_rd = 1'b1;
      OP_LUI:    writes_rd = 1'b1;
      OP_AUIPC:  writes_rd = 1'b1;
      default:   ;
    endcase
  end

  assign wr_en = writes_rd && (rd != 5'd0);

endmodule

// File: rtl/rv32i_hazard_ctrl.sv
// Stall/flush controller for a 5-stage RV32I pipeline without bypassing:
// tracks in-flight destinations in a shadow EX/MEM/WB pipeline.
module rv32i_hazard_ctrl
  import rv32i_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [31:0]      id_iw,
  input  logic             ex_redirect,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_kill,
  output logic             idex_bubble,
  output logic             pc_redirect,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [4:0] rs1, rs2, rd;
  logic       rs1_used, rs2_used, wr_en;

  rv32i_iw_decode u_decode (
    .id_iw    (id_iw),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used),
    .wr_en    (wr_en),
    .rd       (rd)
  );

  hz_state_e       state_q, state_d;
  slot_t           ex_q, mem_q, wb_q, ex_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic            rs1_hit, rs2_hit, hazard, issue;

  // WB counts as a conflict: the register file writes and reads in the same cycle without bypass.
  assign rs1_hit = rs1_used && (rs1 != 5'd0) &&
                   (slot_hit(ex_q, rs1) || slot_hit(mem_q, rs1) || slot_hit(wb_q, rs1));
  assign rs2_hit = rs2_used && (rs2 != 5'd0) &&
                   (slot_hit(ex_q, rs2) || slot_hit(mem_q, rs2) || slot_hit(wb_q, rs2));
  assign hazard  = id_valid && (rs1_hit || rs2_hit);

  always_comb begin
    state_d     = ST_RUN;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_kill   = 1'b0;
    idex_bubble = 1'b0;
    pc_redirect = 1'b0;
    issue       = 1'b0;
    if (ex_redirect) begin
      state_d     = ST_FLUSH;
      pc_redirect = 1'b1;
      ifid_kill   = 1'b1;
      idex_bubble = 1'b1;
    end else if (state_q == ST_FLUSH) begin
      // The word in ID was fetched before the redirect took effect; squash it unseen.
      ifid_kill   = 1'b1;
      idex_bubble = 1'b1;
    end else if (hazard) begin
      state_d     = ST_STALL;
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      issue = id_valid;
    end
  end

  assign ex_d = issue ? '{valid: wr_en, rd: rd} : '0;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  // NOTE: the three slots are plain flops, not a memory, so they are reset like any other state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      if (state_d == ST_STALL && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (ex_redirect && flush_cnt_q != '1)         flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign state_o   = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// Directed self-checking bench for rv32i_hazard_ctrl: stalls, redirects,
// flush squashing, async reset and counter saturation.
module tb_rv32i_hazard_ctrl;

  localparam logic [31:0] ADDI_X5_X0_1 = 32'h0010_0293;
  localparam logic [31:0] ADD_X6_X5_X5 = 32'h0052_8333;
  localparam logic [31:0] ADDI_X0_X0_1 = 32'h0010_0013;
  localparam logic [31:0] ADD_X6_X0_X0 = 32'h0000_0333;
  localparam logic [31:0] JAL_X1       = 32'h0000_00EF;
  localparam logic [31:0] ADDI_X7_X0_0 = 32'h0000_0393;
  localparam logic [31:0] ADDI_X8_X1_0 = 32'h0000_8413;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [31:0] id_iw;
  logic        ex_redirect;
  logic        pc_stall, ifid_stall, ifid_kill, idex_bubble, pc_redirect;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt, flush_cnt;

  int n_chk = 0;
  int n_bad = 0;

  rv32i_hazard_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .id_valid    (id_valid),
    .id_iw       (id_iw),
    .ex_redirect (ex_redirect),
    .pc_stall    (pc_stall),
    .ifid_stall  (ifid_stall),
    .ifid_kill   (ifid_kill),
    .idex_bubble (idex_bubble),
    .pc_redirect (pc_redirect),
    .state_o     (state_o),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packs {pc_stall, ifid_stall, ifid_kill, idex_bubble, pc_redirect}.
  function automatic logic [4:0] ctl();
    return {pc_stall, ifid_stall, ifid_kill, idex_bubble, pc_redirect};
  endfunction

  // Advance to just after the next rising edge, then let combinational outputs settle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] iw, input logic redir);
    id_valid    = v;
    id_iw       = iw;
    ex_redirect = redir;
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    repeat (2) cyc();
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    reset_n = 1'b1;
    cyc();
    check("idle_ctl", 32'(ctl()), 32'd0);
    cyc();
    check("idle_ctl2", 32'(ctl()), 32'd0);

    // x0 as destination and source never creates a dependency.
    drive(1'b1, ADDI_X0_X0_1, 1'b0);
    check("x0_wr_ctl", 32'(ctl()), 32'd0);
    cyc();
    drive(1'b1, ADD_X6_X0_X0, 1'b0);
    check("x0_rd_ctl", 32'(ctl()), 32'd0);
    cyc();
    drive(1'b0, 32'h0, 1'b0);
    repeat (3) cyc();
    check("x0_stall_cnt", 32'(stall_cnt), 32'd0);
    check("x0_state", 32'(state_o), 32'd0);

    // RAW on x5 back-to-back: stall while x5 sits in EX, MEM, WB.
    drive(1'b1, ADDI_X5_X0_1, 1'b0);
    check("raw_issue_ctl", 32'(ctl()), 32'd0);
    cyc();
    drive(1'b1, ADD_X6_X5_X5, 1'b0);
    check("raw_s1_ctl", 32'(ctl()), 32'b11010);
    check("raw_s1_state", 32'(state_o), 32'd0);
    cyc();
    check("raw_s2_ctl", 32'(ctl()), 32'b11010);
    check("raw_s2_state", 32'(state_o), 32'd1);
    cyc();
    check("raw_s3_ctl", 32'(ctl()), 32'b11010);
    check("raw_s3_state", 32'(state_o), 32'd1);
    cyc();
    check("raw_go_ctl", 32'(ctl()), 32'd0);
    check("raw_go_state", 32'(state_o), 32'd1);
    cyc();
    drive(1'b0, 32'h0, 1'b0);
    check("raw_end_state", 32'(state_o), 32'd0);
    check("raw_stall_cnt", 32'(stall_cnt), 32'd3);
    repeat (3) cyc();

    // One-cycle redirect pulse, then a FLUSH cycle.
    drive(1'b0, 32'h0, 1'b1);
    check("redir_ctl", 32'(ctl()), 32'b00111);
    cyc();
    drive(1'b0, 32'h0, 1'b0);
    check("flush_ctl", 32'(ctl()), 32'b00110);
    check("flush_state", 32'(state_o), 32'd2);
    cyc();
    check("post_flush_ctl", 32'(ctl()), 32'd0);
    check("post_flush_state", 32'(state_o), 32'd0);
    check("flush_cnt1", 32'(flush_cnt), 32'd1);

    // JAL x1 redirects from EX; its rd must still shift down and block a reader of x1.
    drive(1'b1, JAL_X1, 1'b0);
    cyc();
    drive(1'b1, ADDI_X7_X0_0, 1'b1);
    check("jal_redir_ctl", 32'(ctl()), 32'b00111);
    cyc();
    drive(1'b1, ADDI_X8_X1_0, 1'b0);
    check("jal_flush_ctl", 32'(ctl()), 32'b00110);
    cyc();
    check("jal_wb_hazard_ctl", 32'(ctl()), 32'b11010);
    cyc();
    check("jal_clear_ctl", 32'(ctl()), 32'd0);
    cyc();
    drive(1'b0, 32'h0, 1'b0);
    check("jal_stall_cnt", 32'(stall_cnt), 32'd4);
    check("jal_flush_cnt", 32'(flush_cnt), 32'd2);
    repeat (3) cyc();

    // Redirect coincident with a hazard: redirect wins, no stall counted.
    drive(1'b1, ADDI_X5_X0_1, 1'b0);
    cyc();
    drive(1'b1, ADD_X6_X5_X5, 1'b1);
    check("coinc_ctl", 32'(ctl()), 32'b00111);
    cyc();
    drive(1'b1, ADD_X6_X5_X5, 1'b0);
    check("coinc_flush_ctl", 32'(ctl()), 32'b00110);
    check("coinc_stall_cnt", 32'(stall_cnt), 32'd4);
    check("coinc_flush_cnt", 32'(flush_cnt), 32'd3);
    cyc();
    drive(1'b0, 32'h0, 1'b0);
    repeat (3) cyc();

    // Asynchronous reset asserted in the middle of a stall.
    drive(1'b1, ADDI_X5_X0_1, 1'b0);
    cyc();
    drive(1'b1, ADD_X6_X5_X5, 1'b0);
    check("mid_stall_ctl", 32'(ctl()), 32'b11010);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_ctl", 32'(ctl()), 32'd0);
    check("arst_state", 32'(state_o), 32'd0);
    check("arst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("arst_flush_cnt", 32'(flush_cnt), 32'd0);
    check("arst_slots", 32'({dut.ex_q.valid, dut.mem_q.valid, dut.wb_q.valid}), 32'd0);
    cyc();
    reset_n = 1'b1;
    #1;
    check("rel_ctl", 32'(ctl()), 32'd0);
    cyc();
    check("rel_ctl2", 32'(ctl()), 32'd0);
    check("rel_stall_cnt", 32'(stall_cnt), 32'd0);
    drive(1'b0, 32'h0, 1'b0);
    repeat (3) cyc();

    // Sustained hazard long enough to saturate the stall counter.
    drive(1'b1, ADD_X6_X5_X5, 1'b0);
    force dut.hazard = 1'b1;
    repeat (70000) cyc();
    check("sat_ctl", 32'(ctl()), 32'b11010);
    release dut.hazard;
    drive(1'b0, 32'h0, 1'b0);
    cyc();
    check("sat_stall_cnt", 32'(stall_cnt), 32'h0000_FFFF);
    check("sat_flush_cnt", 32'(flush_cnt), 32'd0);
    check("sat_state", 32'(state_o), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
